bus_store_checker: RTL and testbench

//  Parametrised store scoreboard for cpu6502 unit benches.
//  - Bench loads an ordered list of expected CPU writes (addr, data) into an internal queue.
//  - Block snoops the CPU bus, compares every write against the queue head, and counts matches.
//  - Latches the first mismatch, unexpected write or timeout.
//  - Replaces hand-placed per-cycle address/data checks, so tests no longer depend on exact cycle stamps.

---
 rtl/bus_chk_pkg.sv | 22 ++
 rtl/bus_store_checker_if.sv | 28 ++
 rtl/bus_chk_fifo.sv | 47 ++++
 rtl/bus_store_checker.sv | 116 +++++++++++
 tb/tb_bus_store_checker.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_chk_pkg.sv
// Shared definitions for the bus store checker: FSM state encoding,
// error codes and a saturating counter helper.
package bus_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_MISMATCH   = 2'd1;
    localparam logic [1:0] ERR_UNEXPECTED = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

    // Increment that sticks at the maximum value instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bus_store_checker_if.sv
// Expected-write push channel plus the snooped CPU bus. The bench side
// drives everything except exp_ready; the checker only observes the bus.
interface bus_store_checker_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              exp_valid;
    logic              exp_ready;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_odata;
    logic              bus_rw;
    logic              bus_stb;

    modport master (
        output exp_valid, exp_addr, exp_data,
        output bus_addr, bus_odata, bus_rw, bus_stb,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_addr, exp_data,
        input  bus_addr, bus_odata, bus_rw, bus_stb,
        output exp_ready
    );
endinterface

// File: rtl/bus_chk_fifo.sv
// Expected-write queue. Pointers carry one extra bit so full and empty are
// distinguishable when the index bits coincide; push and pop may happen in
// the same cycle.
module bus_chk_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[PW-1:0]];

    // Advance pointers on accepted push/pop; wrap comes free from the width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Write storage on accepted push.
    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end
endmodule

// File: rtl/bus_store_checker.sv
// Store scoreboard: the bench loads the expected CPU writes in order, then
// arms the checker, which compares each snooped write against the queue head
// and latches the first mismatch, unexpected write or timeout.
module bus_store_checker
    import bus_chk_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bus_store_checker_if.slave   bif,
    input  logic                 arm,
    output logic                 done,
    output logic                 fail,
    output logic [1:0]           err_code,
    output logic [ADDR_W-1:0]    err_addr,
    output logic [DATA_W-1:0]    err_data,
    output logic [7:0]           match_cnt
);
    // Counts 0..TIMEOUT-1 idle cycles; the TIMEOUT-th idle cycle trips the error.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t                   state;
    logic [TW-1:0]            tmo_cnt;
    logic                     wr_ev;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic                     head_match;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;

    assign wr_ev         = bif.bus_stb && !bif.bus_rw;
    assign bif.exp_ready = (state == ST_IDLE) && !full;
    assign push          = bif.exp_valid && bif.exp_ready;
    assign head_addr     = head[ADDR_W+DATA_W-1 -: ADDR_W];
    assign head_data     = head[DATA_W-1:0];
    assign head_match    = (bif.bus_addr == head_addr) && (bif.bus_odata == head_data);
    assign pop           = (state == ST_ARMED) && wr_ev && !empty && head_match;
    assign done          = (state == ST_PASS);
    assign fail          = (state == ST_FAIL);

    bus_chk_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({bif.exp_addr, bif.exp_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    // Checker FSM with timeout counter, match counter and error capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            err_code  <= ERR_NONE;
            err_addr  <= '0;
            err_data  <= '0;
            match_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (arm) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (wr_ev) begin
                        if (empty) begin
                            state    <= ST_FAIL;
                            err_code <= ERR_UNEXPECTED;
                            err_addr <= bif.bus_addr;
                            err_data <= bif.bus_odata;
                        end else if (head_match) begin
                            match_cnt <= sat_inc8(match_cnt);
                            tmo_cnt   <= '0;
                        end else begin
                            state    <= ST_FAIL;
                            err_code <= ERR_MISMATCH;
                            err_addr <= bif.bus_addr;
                            err_data <= bif.bus_odata;
                        end
                    end else if (empty) begin
                        state <= ST_PASS;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        state    <= ST_FAIL;
                        err_code <= ERR_TIMEOUT;
                        err_addr <= head_addr;
                        err_data <= head_data;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_PASS: begin
                    if (wr_ev) begin
                        state    <= ST_FAIL;
                        err_code <= ERR_UNEXPECTED;
                        err_addr <= bif.bus_addr;
                        err_data <= bif.bus_odata;
                    end
                end
                default: ; // ST_FAIL holds everything until reset
            endcase
        end
    end
endmodule

// File: tb/tb_bus_store_checker.sv
// Directed bench for bus_store_checker. Stimulus pushes the expected final
// outcome of each scenario into a scoreboard queue; a monitor pops and
// compares whenever done or fail changes to a new non-idle value.
module tb_bus_store_checker;
    import bus_chk_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              arm = 1'b0;
    logic              done;
    logic              fail;
    logic [1:0]        err_code;
    logic [ADDR_W-1:0] err_addr;
    logic [DATA_W-1:0] err_data;
    logic [7:0]        match_cnt;

    bus_store_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    bus_store_checker #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bif       (bif.slave),
        .arm       (arm),
        .done      (done),
        .fail      (fail),
        .err_code  (err_code),
        .err_addr  (err_addr),
        .err_data  (err_data),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        done;
        logic        fail;
        logic [1:0]  code;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  cnt;
    } outcome_t;

    outcome_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_outcome(input int id, input logic d, input logic f, input logic [1:0] c,
                                  input logic [15:0] a, input logic [7:0] dt, input logic [7:0] n);
        outcome_t o;
        o.id = id; o.done = d; o.fail = f; o.code = c; o.addr = a; o.data = dt; o.cnt = n;
        sb_q.push_back(o);
    endtask

    // Monitor: compare every new done/fail outcome against the scoreboard head.
    initial begin
        logic [1:0] prev;
        outcome_t   e;
        prev = 2'b00;
        forever begin
            @(negedge clk);
            if (reset_n && {done, fail} != prev && {done, fail} != 2'b00) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_outcome", {30'd0, done, fail}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("t%0d_done", e.id),      done,      e.done);
                    check($sformatf("t%0d_fail", e.id),      fail,      e.fail);
                    check($sformatf("t%0d_err_code", e.id),  err_code,  e.code);
                    check($sformatf("t%0d_err_addr", e.id),  err_addr,  e.addr);
                    check($sformatf("t%0d_err_data", e.id),  err_data,  e.data);
                    check($sformatf("t%0d_match_cnt", e.id), match_cnt, e.cnt);
                end
            end
            prev = {done, fail};
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bif.exp_valid = 1'b1;
        bif.exp_addr  = a;
        bif.exp_data  = d;
        @(negedge clk);
        bif.exp_valid = 1'b0;
    endtask

    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
        @(negedge clk);
        bif.bus_stb   = 1'b1;
        bif.bus_rw    = rw;
        bif.bus_addr  = a;
        bif.bus_odata = d;
        @(negedge clk);
        bif.bus_stb   = 1'b0;
        bif.bus_rw    = 1'b1;
    endtask

    task automatic arm_pulse();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, sb_q.size() == 0}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_done"},      done,          0);
        check({tag, "_fail"},      fail,          0);
        check({tag, "_err_code"},  err_code,      0);
        check({tag, "_err_addr"},  err_addr,      0);
        check({tag, "_err_data"},  err_data,      0);
        check({tag, "_match_cnt"}, match_cnt,     0);
        check({tag, "_exp_ready"}, bif.exp_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.exp_valid = 1'b0;
        bif.exp_addr  = '0;
        bif.exp_data  = '0;
        bif.bus_addr  = '0;
        bif.bus_odata = '0;
        bif.bus_rw    = 1'b1;
        bif.bus_stb   = 1'b0;

        // Reset state
        do_reset();
        check_reset_values("rst");

        // 1: single matching write; IDLE write and armed read strobe are ignored
        expect_outcome(1, 1'b1, 1'b0, ERR_NONE, 16'h0000, 8'h00, 8'd1);
        push(16'h0099, 8'hff);
        bus_cycle(16'h0099, 8'hff, 1'b0);
        arm_pulse();
        bus_cycle(16'h0099, 8'hff, 1'b1);
        bus_cycle(16'h0099, 8'hff, 1'b0);
        check("t1_done_not_yet", done, 0);
        @(negedge clk);
        check("t1_done_next_cycle", done, 1);
        wait_drain("t1_drain", 20);

        // 2: data mismatch
        do_reset();
        expect_outcome(2, 1'b0, 1'b1, ERR_MISMATCH, 16'h0099, 8'hfe, 8'd0);
        push(16'h0099, 8'hff);
        arm_pulse();
        bus_cycle(16'h0099, 8'hfe, 1'b0);
        wait_drain("t2_drain", 20);

        // 3: fill queue, overflow push dropped, drain with 8 matches
        do_reset();
        expect_outcome(3, 1'b1, 1'b0, ERR_NONE, 16'h0000, 8'h00, 8'd8);
        for (int i = 0; i < DEPTH; i++) begin
            push(16'h0300 + 16'(i), 8'h10 + 8'(i));
            check($sformatf("t3_exp_ready_after_%0d", i + 1), bif.exp_ready, (i < DEPTH - 1) ? 1 : 0);
        end
        push(16'h0400, 8'haa);
        arm_pulse();
        check("t3_exp_ready_armed", bif.exp_ready, 0);
        for (int i = 0; i < DEPTH; i++) begin
            bus_cycle(16'h0300 + 16'(i), 8'h10 + 8'(i), 1'b0);
        end
        wait_drain("t3_drain", 20);

        // 4: timeout exactly TIMEOUT cycles after arm
        do_reset();
        expect_outcome(4, 1'b0, 1'b1, ERR_TIMEOUT, 16'h0010, 8'h01, 8'd0);
        push(16'h0010, 8'h01);
        arm_pulse();
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (k == TIMEOUT - 1) check("t4_no_fail_before_timeout", fail, 0);
            if (k == TIMEOUT)     check("t4_fail_at_timeout", fail, 1);
        end
        wait_drain("t4_drain", 20);

        // 5: arm with empty queue -> PASS, then an unexpected write
        do_reset();
        expect_outcome(5, 1'b1, 1'b0, ERR_NONE, 16'h0000, 8'h00, 8'd0);
        expect_outcome(6, 1'b0, 1'b1, ERR_UNEXPECTED, 16'h0200, 8'h55, 8'd0);
        arm_pulse();
        repeat (3) @(negedge clk);
        check("t5_done_empty_arm", done, 1);
        bus_cycle(16'h0200, 8'h55, 1'b0);
        @(negedge clk);
        check("t5_done_dropped", done, 0);
        wait_drain("t5_drain", 20);

        // 6: reset mid-run after one of three matches; queue must be cleared
        do_reset();
        push(16'h0500, 8'ha0);
        push(16'h0501, 8'ha1);
        push(16'h0502, 8'ha2);
        arm_pulse();
        bus_cycle(16'h0500, 8'ha0, 1'b0);
        check("t6_match_cnt_before_reset", match_cnt, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("t6_rst");
        @(negedge clk);
        reset_n = 1'b1;
        expect_outcome(7, 1'b1, 1'b0, ERR_NONE, 16'h0000, 8'h00, 8'd0);
        arm_pulse();
        wait_drain("t6_drain", 20);

        check("sb_empty_at_end", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
